serial_add_sub: RTL and testbench
=================================

Name: serial_add_sub

Overview:
- Parametrised bit-serial adder/subtractor: the multi-bit, sequential successor to the single-bit full adder.
- One full-adder cell plus a carry flip-flop processes one operand bit per clock, LSB first.
- A start/busy/done handshake frames each operation.
- Intended for area-constrained datapaths where WIDTH-cycle latency is acceptable.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH+1), bit-index counter width; derived, not overridden.

Ports:
- clk  input  1  single system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- c_in  input  1  carry-in (add) / borrow-in (sub), captured on accepted start
- sub  input  1  0 = A+B+c_in, 1 = A-B-c_in; captured on accepted start
- busy  output  1  high while operation in progress (RUN state)
- done  output  1  one-cycle pulse: result valid
- sum  output  WIDTH  registered result
- c_out  output  1  carry-out; in sub mode, 1 = no borrow
- overflow  output  1  two's-complement signed overflow of last result

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; busy=0, done=0, sum=0, c_out=0, overflow=0; counter, carry and operand shift registers cleared.
- rst has priority over all other inputs in every state.
- rst mid-RUN aborts the operation: no done pulse, outputs return to 0.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at edge:
  - load A shift reg = a.
  - load B shift reg = b when sub=0, ~b when sub=1.
  - carry = c_in when sub=0, ~c_in when sub=1.
  - bit counter = 0; go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, each edge:
  - s = A0 ^ B0 ^ carry.
  - carry <= (A0&B0) | (carry&(A0^B0)).
  - s shifts into the MSB of the internal result shift reg.
  - A and B shift right; counter increments.
  - On the edge processing bit WIDTH-1, go to DONE.
- RUN timing: exactly WIDTH edges in RUN.
- DONE entry, same edge as the final bit:
  - sum <= internal result; c_out <= final carry.
  - overflow <= carry into MSB XOR final carry; record carry-into-MSB when processing bit WIDTH-1.
- DONE: done=1 for exactly one cycle, then unconditionally to IDLE.
- Latency: start accepted at edge k, so done is high in the cycle after edge k+WIDTH, and busy is high for cycles k+1..k+WIDTH.
- busy is 0 in IDLE and DONE.
- Back-to-back throughput: one operation per WIDTH+2 cycles.
- start while busy or in DONE is ignored, with no queuing; in-flight operands are unaffected by input changes.
- sum, c_out and overflow change only on DONE entry or reset, and hold the last result indefinitely in IDLE.
- Arithmetic is modulo 2^WIDTH; no saturation.

Test Plan (WIDTH=8):
- Reset, then start with a=0x00, b=0x00, c_in=0, sub=0 -> busy high 8 cycles, done pulse 1 cycle at start+9; sum=0x00, c_out=0, overflow=0.
- Add a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1, overflow=0. Then add a=0x7F, b=0x00, c_in=1 -> sum=0x80, c_out=0, overflow=1.
- Sub a=0x05, b=0x07, c_in=0 -> sum=0xFE, c_out=0, overflow=0. Sub a=0x80, b=0x01, c_in=0 -> sum=0x7F, c_out=1, overflow=1.
- Start (0x12+0x34) is accepted; start re-pulsed at cycles 3 and 8 with a=0xAA -> both ignored; single done with sum=0x46; outputs hold 0x46 while idle.
- rst asserted for 1 cycle at the 4th RUN cycle of 0x0F+0x01 -> busy=0 and all outputs 0 the next cycle, no done. New start 0x10+0x20 -> sum=0x30 with normal latency.
- Randomised sweep of 1000 operations (random a, b, c_in, sub) plus back-to-back starts with start held high -> every result matches a reference model, including c_out and overflow; done spacing is exactly 10 cycles.

Source files
------------

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop,
// processing one operand bit per clock, LSB first, framed by start/busy/done.
module serial_add_sub #(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:1] res_q;
    logic [WIDTH-1:0] sum_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;
    logic             cout_q;
    logic             ovf_q;

    logic             bit_s;
    logic             carry_d;
    logic [WIDTH-1:0] res_d;
    logic             last_bit;

    always_comb begin
        bit_s    = a_q[0] ^ b_q[0] ^ carry_q;
        carry_d  = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
        res_d    = {bit_s, res_q};
        last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        // Subtraction is A + ~B + ~borrow_in.
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= c_in ^ sub;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= carry_d;
                    res_q   <= res_d[WIDTH-1:1];
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        // carry_q is the carry into the MSB here.
                        sum_q   <= res_d;
                        cout_q  <= carry_d;
                        ovf_q   <= carry_q ^ carry_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign c_out    = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub: directed cases, abort by reset,
// ignored starts and a back-to-back random sweep against an arithmetic model.
module tb_serial_add_sub;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
    logic         overflow;

    int           errors = 0;
    int           checks = 0;
    longint       cyc = 0;
    logic [W+1:0] exp_q[$];
    logic [W+1:0] e;
    bit           b2b = 0;
    bit           have_prev = 0;
    longint       prev_done = 0;

    serial_add_sub #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .a(a),
        .b(b),
        .c_in(c_in),
        .sub(sub),
        .busy(busy),
        .done(done),
        .sum(sum),
        .c_out(c_out),
        .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Plain integer arithmetic: {sum, carry/no-borrow, signed overflow}
    function automatic logic [W+1:0] ref_model(input logic [W-1:0] ta,
                                               input logic [W-1:0] tb,
                                               input logic tc,
                                               input logic ts);
        longint ua = longint'(ta);
        longint ub = longint'(tb);
        longint sa = longint'($signed(ta));
        longint sb = longint'($signed(tb));
        longint ci = longint'(tc);
        longint r;
        longint sr;
        logic co;
        logic ov;
        logic [W-1:0] rs;
        if (!ts) begin
            r  = ua + ub + ci;
            sr = sa + sb + ci;
            co = (r >= (longint'(1) << W));
        end else begin
            r  = ua - ub - ci;
            sr = sa - sb - ci;
            co = (r >= 0);
        end
        ov = (sr > (longint'(1) << (W - 1)) - 1) ||
             (sr < -(longint'(1) << (W - 1)));
        rs = r[W-1:0];
        return {rs, co, ov};
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done sum=%0h want no done",
                         sum);
            end else begin
                e = exp_q.pop_front();
                chk("result", {sum, c_out, overflow}, e);
            end
            if (b2b) begin
                if (have_prev) chk("done_spacing", cyc - prev_done, 10);
                prev_done = cyc;
                have_prev = 1;
            end
        end
    end

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tc, input logic ts);
        @(negedge clk);
        a = ta;
        b = tb;
        c_in = tc;
        sub = ts;
        start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (busy) break;
        end
        if (busy) exp_q.push_back(ref_model(ta, tb, tc, ts));
        else chk("accept_timeout", busy, 1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) break;
        end
        if (!done) chk({nm, "_timeout"}, done, 1);
    endtask

    task automatic measure(input string nm);
        int n = 0;
        int bc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (busy) bc++;
            if (done) break;
        end
        chk({nm, "_done_at"}, n, 9);
        chk({nm, "_busy_cycles"}, bc, 8);
        @(negedge clk);
        chk({nm, "_done_width"}, done, 0);
    endtask

    task automatic run_dir(input string nm, input logic [W-1:0] ta,
                           input logic [W-1:0] tb, input logic tc,
                           input logic ts, input logic [W-1:0] xs,
                           input logic xc, input logic xo);
        do_op(ta, tb, tc, ts);
        wait_done(nm);
        chk(nm, {sum, c_out, overflow}, {xs, xc, xo});
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        c_in = 1'b0;
        sub = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_outs", {busy, done, sum, c_out, overflow}, '0);

        do_op(8'h00, 8'h00, 1'b0, 1'b0);
        measure("first");
        chk("zero_add", {sum, c_out, overflow}, {8'h00, 1'b0, 1'b0});

        run_dir("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        run_dir("add_7f_ci", 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1);
        run_dir("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        run_dir("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

        do_op(8'h12, 8'h34, 1'b0, 1'b0);
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 3 || n == 8) begin
                start = 1'b1;
                a = 8'hAA;
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        start = 1'b0;
        chk("ign_done", done, 1);
        chk("ign_sum", sum, 8'h46);
        repeat (3) begin
            @(negedge clk);
            chk("hold_sum", sum, 8'h46);
            chk("hold_busy", busy, 0);
        end

        do_op(8'h0F, 8'h01, 1'b0, 1'b0);
        for (int n = 1; n <= 4; n++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(exp_q.pop_back());
        chk("abort_outs", {busy, done, sum, c_out, overflow}, '0);
        repeat (12) @(negedge clk);
        chk("abort_idle", busy, 0);

        do_op(8'h10, 8'h20, 1'b0, 1'b0);
        measure("after_rst");
        chk("after_rst_sum", sum, 8'h30);

        @(negedge clk);
        b2b = 1;
        have_prev = 0;
        start = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic rc;
            logic rsb;
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            rsb = 1'($urandom);
            a = ra;
            b = rb;
            c_in = rc;
            sub = rsb;
            for (int j = 0; j < 30; j++) begin
                @(posedge clk);
                #1;
                if (busy) break;
            end
            if (!busy) begin
                chk("sweep_accept", busy, 1);
                break;
            end
            exp_q.push_back(ref_model(ra, rb, rc, rsb));
            for (int j = 0; j < 30; j++) begin
                @(posedge clk);
                #1;
                if (!busy) break;
            end
        end
        start = 1'b0;
        repeat (4) @(negedge clk);
        b2b = 0;

        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
